// File: rtl/fxp_defs_pkg.sv
// Shared constants for the fixed-point gain blocks: gain format, result width,
// saturation limits and the multiplier FSM state encodings.
package fxp_defs_pkg;

    // Gain format: sign-magnitude, 1 sign + INT_BITS integer + FRAC_BITS fraction
    localparam int unsigned INT_BITS  = 9;
    localparam int unsigned FRAC_BITS = 10;
    localparam int unsigned DATA_W    = 16;

    localparam int unsigned FMT_W     = 1 + INT_BITS + FRAC_BITS;
    localparam int unsigned SIGN_BIT  = FMT_W - 1;
    localparam int unsigned MAG_X_W   = INT_BITS + FRAC_BITS;

    // |B| needs one extra bit so that -32768 maps to +32768
    localparam int unsigned MAG_B_W   = DATA_W + 1;

    // Accumulator holds the full magnitude product plus rounding headroom
    localparam int unsigned ACC_W     = 36;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned LAST_BIT  = MAG_X_W - 1;

    // Result clamp limits
    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
    localparam int unsigned POS_LIM = 32767;
    localparam int unsigned NEG_LIM = 32768;

    // FSM encodings
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

endpackage

// File: rtl/fxp_saturate.sv
// Combinational sign-apply and clamp: turns a sign plus an unsigned magnitude
// into a DATA_W two's-complement value and a clamp flag. A zero magnitude is
// always +0 regardless of sign.
module fxp_saturate
    import fxp_defs_pkg::*;
#(
    parameter int unsigned MAG_W = ACC_W
) (
    input  logic                     neg,
    input  logic [MAG_W-1:0]         mag,
    output logic signed [DATA_W-1:0] y_c,
    output logic                     sat_c
);

    // Apply sign and clamp to the representable range
    always_comb begin
        y_c   = '0;
        sat_c = 1'b0;
        if (mag == '0) begin
            y_c   = '0;
            sat_c = 1'b0;
        end else if (!neg) begin
            if (mag > MAG_W'(POS_LIM)) begin
                y_c   = SAT_MAX;
                sat_c = 1'b1;
            end else begin
                y_c = DATA_W'(mag);
            end
        end else begin
            if (mag > MAG_W'(NEG_LIM)) begin
                y_c   = SAT_MIN;
                sat_c = 1'b1;
            end else begin
                y_c = DATA_W'(~mag + MAG_W'(1));
            end
        end
    end

endmodule

// File: rtl/fixed_point_multiplier.sv
// Iterative shift-add multiplier: scales a signed 16-bit integer by a 20-bit
// sign-magnitude fixed-point gain, one gain bit per clock, with saturated
// 16-bit output and start/busy/done handshake.
// Optional build macro FXP_MUL_ROUND_EN: round half away from zero on the
// magnitude instead of truncating.
module fixed_point_multiplier
    import fxp_defs_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FMT_W-1:0]         X,
    input  logic [DATA_W-1:0]        B,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] Y,
    output logic                     sat
);

`ifdef FXP_MUL_ROUND_EN
    localparam logic [ACC_W-1:0] RND_ADD = ACC_W'(1) << (FRAC_BITS - 1);
`else
    localparam logic [ACC_W-1:0] RND_ADD = '0;
`endif

    logic [1:0]               state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [ACC_W-1:0]         acc, acc_nxt;
    logic [MAG_X_W-1:0]       magx, magx_nxt;
    logic [MAG_B_W-1:0]       magb, magb_nxt;
    logic                     sgn, sgn_nxt;
    logic                     busy_nxt, done_nxt, sat_nxt;
    logic signed [DATA_W-1:0] y_nxt;

    logic [MAG_B_W-1:0]       b_ext;
    logic [ACC_W-1:0]         rounded;
    logic [ACC_W-1:0]         shifted;
    logic signed [DATA_W-1:0] sat_y_c;
    logic                     sat_flag_c;

    // Operand magnitude and final scaling datapath
    always_comb begin
        b_ext   = {B[DATA_W-1], B};
        rounded = acc + RND_ADD;
        shifted = rounded >> FRAC_BITS;
    end

    fxp_saturate #(
        .MAG_W (ACC_W)
    ) u_sat (
        .neg   (sgn),
        .mag   (shifted),
        .y_c   (sat_y_c),
        .sat_c (sat_flag_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        magx_nxt  = magx;
        magb_nxt  = magb;
        sgn_nxt   = sgn;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        y_nxt     = Y;
        sat_nxt   = sat;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    magx_nxt  = X[MAG_X_W-1:0];
                    sgn_nxt   = X[SIGN_BIT] ^ B[DATA_W-1];
                    magb_nxt  = B[DATA_W-1] ? (~b_ext + MAG_B_W'(1)) : b_ext;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (magx[cnt]) begin
                    acc_nxt = acc + (ACC_W'(magb) << cnt);
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(LAST_BIT)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                y_nxt     = sat_y_c;
                sat_nxt   = sat_flag_c;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            magx  <= '0;
            magb  <= '0;
            sgn   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Y     <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            magx  <= magx_nxt;
            magb  <= magb_nxt;
            sgn   <= sgn_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            Y     <= y_nxt;
            sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Scoreboard bench for fixed_point_multiplier: the driver pushes hand-computed
// results, a negedge monitor pops and compares on every done pulse.
module tb_fixed_point_multiplier;

    logic               clk;
    logic               rst;
    logic               start;
    logic [19:0]        X;
    logic [15:0]        B;
    logic               busy;
    logic               done;
    logic signed [15:0] Y;
    logic               sat;

    typedef struct {
        logic signed [15:0] y;
        logic               s;
        int                 cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   ndone  = 0;

    fixed_point_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            ndone = ndone + 1;
            ntests = ntests + 1;
            if (exp_q.size() == 0) begin
                nfail = nfail + 1;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (Y !== e.y || sat !== e.s || cyc != e.cyc) begin
                    nfail = nfail + 1;
                    $display("FAIL result: got Y=%0d sat=%0b cyc=%0d, required Y=%0d sat=%0b cyc=%0d",
                             Y, sat, cyc, e.y, e.s, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        ntests = ntests + 1;
        if (got !== req) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Issue one operation at the current negedge; returns at the negedge where done is high.
    // inject >= 0 pulses an extra (to-be-ignored) start that many cycles in.
    task automatic run_op(input logic [19:0] x, input logic [15:0] b,
                          input logic signed [15:0] ey, input logic es, input int inject);
        exp_t e;
        logic bad;
        int   n;
        X = x;
        B = b;
        start = 1'b1;
        e.y = ey;
        e.s = es;
        e.cyc = cyc + 21;
        exp_q.push_back(e);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == inject) begin
                X = 20'h00800;
                B = 16'd999;
                start = 1'b1;
            end else begin
                X = 20'hAAAAA;
                B = 16'h5555;
            end
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        check("busy_window", 32'(bad), 32'd0);
        check("done_timeout", 32'(n), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        X = '0;
        B = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_y", 32'(Y), 32'd0);
        check("reset_sat", 32'(sat), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Main function, issued back to back in the done cycle
        run_op(20'h00400, 16'd1234, 16'sd1234, 1'b0, -1);
        run_op(20'h80A00, 16'd100, -16'sd250, 1'b0, -1);
        run_op(20'h80A00, -16'sd100, 16'sd250, 1'b0, -1);
`ifdef FXP_MUL_ROUND_EN
        run_op(20'h00200, 16'd3, 16'sd2, 1'b0, -1);
        run_op(20'h00200, -16'sd3, -16'sd2, 1'b0, -1);
        run_op(20'h00199, 16'd10, 16'sd4, 1'b0, -1);
`else
        run_op(20'h00200, 16'd3, 16'sd1, 1'b0, -1);
        run_op(20'h00200, -16'sd3, -16'sd1, 1'b0, -1);
        run_op(20'h00199, 16'd10, 16'sd3, 1'b0, -1);
`endif
        run_op(20'h3FFFF, 16'd32767, 16'sd32767, 1'b1, -1);
        run_op(20'h3FFFF, 16'h8000, -16'sd32768, 1'b1, -1);
        run_op(20'h80000, -16'sd5, 16'sd0, 1'b0, -1);
        run_op(20'h00400, 16'h8000, -16'sd32768, 1'b0, -1);
        run_op(20'h00800, 16'd16384, 16'sd32767, 1'b1, -1);
        run_op(20'h80800, 16'd16384, -16'sd32768, 1'b0, -1);

        // Start while busy is ignored; first operands win
        @(negedge clk);
        run_op(20'h00C00, 16'd7, 16'sd21, 1'b0, 5);
        repeat (25) @(negedge clk);

        // Reset mid-calculation discards the operation
        X = 20'h00400;
        B = 16'd77;
        start = 1'b1;
        repeat (11) @(negedge clk) start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_y", 32'(Y), 32'd0);
        check("midrst_sat", 32'(sat), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        d0 = ndone;
        repeat (30) @(negedge clk);
        check("midrst_no_done", 32'(ndone - d0), 32'd0);

        run_op(20'h00600, -16'sd40, -16'sd60, 1'b0, -1);
        repeat (3) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fixed_point_multiplier.md
Name: fixed_point_multiplier

Overview:
- Sequential multiplier that scales a 16-bit signed integer by a 20-bit sign-magnitude fixed-point gain.
- Gain format: bit19 sign, bits18:10 integer (9 bits), bits9:0 fraction (10 bits).
- Produces a saturated 16-bit signed integer result.
- Sits after ratio/gain computation in the PID path: converts fixed-point gains back into integer actuator/error units.
- Iterative shift-add, one multiplier bit per clock, with start/busy/done handshake.

Parameters:
- INT_BITS, 9, integer magnitude bits of the gain input.
- FRAC_BITS, 10, fraction bits of the gain input; also the result right-shift amount.
- DATA_W, 16, width of the signed integer input B and of the result Y.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- X  in  1+INT_BITS+FRAC_BITS (20)  sign-magnitude fixed-point gain.
- B  in  DATA_W (16)  two's-complement signed integer operand.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse; Y and sat are valid from this cycle onward.
- Y  out  DATA_W (16)  signed result; holds its value until the next done.
- sat  out  1  result was clamped; updated together with Y.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-calculation):
  - state returns to IDLE.
  - busy=0, done=0, Y=0, sat=0; internal accumulator, counter and operand registers cleared.
  - The in-flight operation is discarded.
- States:
  - IDLE: start=1 latches magX=X[18:0], sgn=X[19]^B[15], magB=|B| (17 bits; -32768 maps to 32768), clears accumulator, counter=0, goes to CALC.
  - CALC: if magX[counter]=1, add magB<<counter to a 36-bit accumulator; counter increments. After 19 iterations (counter=18 processed), go to FINISH.
  - FINISH: compute result, register Y and sat, done=1 for this one cycle, busy=0, return to IDLE.
- Latency: start sampled on edge k; done high during the cycle following edge k+20; Y updated on that same edge. Back-to-back start may be issued in the cycle done is high; it is sampled on the next edge.
- start while busy: ignored. No queuing, no error flag.
- Result arithmetic:
  - shifted = accumulator >> FRAC_BITS (rounding per optional feature).
  - Apply sign: negative if sgn=1 and shifted≠0. A -0 gain, or a zero product, yields Y=0 and sat=0.
  - Saturation: positive magnitude >32767 gives Y=32767, sat=1. Negative magnitude >32768 gives Y=-32768, sat=1.
- Inputs X and B may change freely after start is accepted; only the latched copies are used.

Optional Feature:
- Macro: FXP_MUL_ROUND_EN.
- Defined: add 2^(FRAC_BITS-1)=512 to the accumulator before the shift, i.e. round half away from zero on the magnitude.
- Undefined: plain truncation of the magnitude (round toward zero).
- Latency, saturation and handshake are identical in both builds.

Decomposition:
- Shared package/include fxp_defs holds:
  - INT_BITS, FRAC_BITS, DATA_W.
  - Sign-bit index (19) and format width (20).
  - State encodings IDLE/CALC/FINISH.
  - SAT_MAX=32767 and SAT_MIN=-32768.
- One natural sub-module: fxp_saturate (combinational). Takes sign plus wide magnitude; produces the DATA_W result and the sat flag. It is reusable by other fixed-point blocks.

Test Plan:
- X=0x00400 (+1.0), B=1234, start pulse → done exactly 20 cycles later, Y=1234, sat=0; busy high in the 20 cycles preceding done.
- X=0x80A00 (-2.5), B=100 → Y=-250, sat=0. Same X with B=-100 → Y=250.
- X=0x00200 (+0.5), B=3 → Y=2 with FXP_MUL_ROUND_EN, Y=1 without. With B=-3 → Y=-2 with the macro, -1 without.
- X=0x3FFFF (+255.999), B=32767 → Y=32767, sat=1. X=0x3FFFF, B=-32768 → Y=-32768, sat=1. X=0x80000 (-0), B=-5 → Y=0, sat=0.
- Second start pulsed 5 cycles after the first (busy=1) → ignored: exactly one done, Y from the first operands. Start re-asserted in the done cycle → second operation completes 20 cycles later.
- rst asserted at CALC iteration 10 → next edge: busy=0, Y=0, sat=0, no done pulse. A fresh start then produces a correct result.
